// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Stall/flush sequencer for the 16-bit fetch/decode/execute
//             pipeline. Tracks outstanding load results in an 8-entry
//             latency scoreboard, stalls fetch+decode on a read-after-load
//             hazard, and squashes decode for a fixed window after a
//             branch mispredict reported by execute.
//  Ports    : clk, reset (sync, active-high)
//             dec_valid, dec_src0/_used, dec_src1/_used, dec_dest,
//             dec_is_load        - decode-stage instruction fields
//             ex_mispredict      - execute resolved a mispredicted branch
//             fetch_stall        - fetcher holds PC
//             decode_stall       - decoder holds, emits NOP
//             decode_flush       - decoder discards, emits NOP
//             sb_busy[7:0]       - scoreboard entry nonzero (debug)
//             perf_stalls/perf_flushes - saturating 16-bit event counts
//  Options  : define PIPE_HAZARD_PERF_CNT_EN to build the perf counters;
//             otherwise perf ports are tied to zero and no flops exist.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT     = 2,   // 1..7
    parameter int FLUSH_CYCLES = 2,   // 1..3
    parameter int DISCARD_REG  = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [2:0]  dec_src0,
    input  logic        dec_src0_used,
    input  logic [2:0]  dec_src1,
    input  logic        dec_src1_used,
    input  logic [2:0]  dec_dest,
    input  logic        dec_is_load,
    input  logic        ex_mispredict,
    output logic        fetch_stall,
    output logic        decode_stall,
    output logic        decode_flush,
    output logic [7:0]  sb_busy,
    output logic [15:0] perf_stalls,
    output logic [15:0] perf_flushes
);

    localparam logic [2:0] c_load_lat    = 3'(LOAD_LAT);
    localparam logic [1:0] c_flush_init  = 2'(FLUSH_CYCLES - 1);
    localparam logic [2:0] c_discard_reg = 3'(DISCARD_REG);

    // Per-register cycles remaining until the load result is readable.
    logic [2:0] r_cnt [0:7];
    // Remaining flush cycles after the current one.
    logic [1:0] r_flush_cnt;

    logic       w_flush_now;
    logic       w_src0_hz;
    logic       w_src1_hz;
    logic       w_hazard;
    logic       w_stall;
    logic       w_flush;
    logic       w_issue;
    logic       w_load_alloc;

    // ------------------------------------------------------------------
    // Flush / hazard decode
    // ------------------------------------------------------------------
    assign w_flush_now = ex_mispredict | (r_flush_cnt != 2'd0);

    // The discard register is never allocated, but the explicit check keeps
    // the hazard independent of whatever its counter happens to hold.
    assign w_src0_hz = dec_src0_used && (dec_src0 != c_discard_reg) &&
                       (r_cnt[dec_src0] != 3'd0);
    assign w_src1_hz = dec_src1_used && (dec_src1 != c_discard_reg) &&
                       (r_cnt[dec_src1] != 3'd0);
    assign w_hazard  = dec_valid & (w_src0_hz | w_src1_hz);

    // All outputs are forced low while reset is asserted, even on the very
    // first reset cycle when the state registers are not yet cleared.
    assign w_flush = w_flush_now & ~reset;
    assign w_stall = w_hazard & ~w_flush_now & ~reset;

    assign fetch_stall  = w_stall;
    assign decode_stall = w_stall;
    assign decode_flush = w_flush;

    assign w_issue      = dec_valid & ~w_stall & ~w_flush_now;
    assign w_load_alloc = w_issue & dec_is_load & (dec_dest != c_discard_reg);

    // ------------------------------------------------------------------
    // Scoreboard: every nonzero entry counts down each cycle, regardless
    // of stall or flush. A new load allocation wins over the decrement, so
    // a repeated load to the same register restarts its full latency.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_load_alloc && (dec_dest == 3'(i))) begin
                    r_cnt[i] <= c_load_lat;
                end else if (r_cnt[i] != 3'd0) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Flush window: a mispredict restarts the window (no accumulation).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt <= 2'd0;
        end else if (ex_mispredict) begin
            r_flush_cnt <= c_flush_init;
        end else if (r_flush_cnt != 2'd0) begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Debug view straight from the scoreboard registers.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 8; g++) begin : g_busy
        assign sb_busy[g] = ~reset & (r_cnt[g] != 3'd0);
    end

    // ------------------------------------------------------------------
    // Optional saturating performance counters.
    // ------------------------------------------------------------------
`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [15:0] r_perf_stalls;
    logic [15:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls  <= 16'd0;
            r_perf_flushes <= 16'd0;
        end else begin
            if (w_stall && (r_perf_stalls != 16'hFFFF)) begin
                r_perf_stalls <= r_perf_stalls + 16'd1;
            end
            if (w_flush && (r_perf_flushes != 16'hFFFF)) begin
                r_perf_flushes <= r_perf_flushes + 16'd1;
            end
        end
    end

    assign perf_stalls  = reset ? 16'd0 : r_perf_stalls;
    assign perf_flushes = reset ? 16'd0 : r_perf_flushes;
`else
    assign perf_stalls  = 16'd0;
    assign perf_flushes = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed scoreboard bench for pipe_hazard_ctrl (default
//             parameters LOAD_LAT=2, FLUSH_CYCLES=2, DISCARD_REG=7).
//             The driver pushes hand-computed expected outputs per cycle;
//             an independent monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        fs;
        logic        ds;
        logic        df;
        logic [7:0]  busy;
        logic [15:0] ps;
        logic [15:0] pf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dec_valid = 1'b0;
    logic [2:0]  dec_src0 = 3'd0;
    logic        dec_src0_used = 1'b0;
    logic [2:0]  dec_src1 = 3'd0;
    logic        dec_src1_used = 1'b0;
    logic [2:0]  dec_dest = 3'd0;
    logic        dec_is_load = 1'b0;
    logic        ex_mispredict = 1'b0;
    logic        fetch_stall;
    logic        decode_stall;
    logic        decode_flush;
    logic [7:0]  sb_busy;
    logic [15:0] perf_stalls;
    logic [15:0] perf_flushes;

    exp_t        exp_q [$];
    string       name_q [$];
    exp_t        r_exp;
    exp_t        r_got;
    string       r_nm;
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] m_stalls  = 16'd0;
    logic [15:0] m_flushes = 16'd0;

    pipe_hazard_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_src0      (dec_src0),
        .dec_src0_used (dec_src0_used),
        .dec_src1      (dec_src1),
        .dec_src1_used (dec_src1_used),
        .dec_dest      (dec_dest),
        .dec_is_load   (dec_is_load),
        .ex_mispredict (ex_mispredict),
        .fetch_stall   (fetch_stall),
        .decode_stall  (decode_stall),
        .decode_flush  (decode_flush),
        .sb_busy       (sb_busy),
        .perf_stalls   (perf_stalls),
        .perf_flushes  (perf_flushes)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus its expected same-cycle outputs.
    task automatic vec(input string nm, input logic rs, input logic v,
                       input logic [2:0] s0, input logic u0,
                       input logic [2:0] s1, input logic u1,
                       input logic [2:0] d, input logic ld, input logic mis,
                       input logic e_st, input logic e_fl,
                       input logic [7:0] e_busy);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rs;
        dec_valid     = v;
        dec_src0      = s0;
        dec_src0_used = u0;
        dec_src1      = s1;
        dec_src1_used = u1;
        dec_dest      = d;
        dec_is_load   = ld;
        ex_mispredict = mis;
        e.fs   = e_st;
        e.ds   = e_st;
        e.df   = e_fl;
        e.busy = e_busy;
`ifdef PIPE_HAZARD_PERF_CNT_EN
        e.ps = rs ? 16'd0 : m_stalls;
        e.pf = rs ? 16'd0 : m_flushes;
        if (rs) begin
            m_stalls  = 16'd0;
            m_flushes = 16'd0;
        end else begin
            if (e_st && m_stalls != 16'hFFFF)   m_stalls  = m_stalls + 16'd1;
            if (e_fl && m_flushes != 16'hFFFF)  m_flushes = m_flushes + 16'd1;
        end
`else
        e.ps = 16'd0;
        e.pf = 16'd0;
`endif
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input string nm, input logic e_fl, input logic [7:0] e_busy);
        vec(nm, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, e_fl, e_busy);
    endtask

    task automatic load(input string nm, input logic [2:0] d, input logic [7:0] e_busy);
        vec(nm, 0, 1, 3'd0, 0, 3'd0, 0, d, 1, 0, 0, 0, e_busy);
    endtask

    // Monitor: compares on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            r_exp = exp_q.pop_front();
            r_nm  = name_q.pop_front();
            r_got = {fetch_stall, decode_stall, decode_flush, sb_busy,
                     perf_stalls, perf_flushes};
            n_vec = n_vec + 1;
            if (r_got !== r_exp) begin
                n_miss = n_miss + 1;
                $display("FAIL %s: got fs=%b ds=%b df=%b busy=%h ps=%h pf=%h, required fs=%b ds=%b df=%b busy=%h ps=%h pf=%h",
                         r_nm, r_got.fs, r_got.ds, r_got.df, r_got.busy, r_got.ps, r_got.pf,
                         r_exp.fs, r_exp.ds, r_exp.df, r_exp.busy, r_exp.ps, r_exp.pf);
            end
        end
    end

    initial begin
        // Reset while decode and mispredict are active: everything low.
        vec("rst0", 1, 1, 3'd3, 1, 3'd2, 1, 3'd3, 1, 1, 0, 0, 8'h00);
        vec("rst1", 1, 1, 3'd3, 1, 3'd2, 1, 3'd3, 1, 1, 0, 0, 8'h00);
        idle("release", 0, 8'h00);

        // Back-to-back load r3 / reader: exactly two stall cycles.
        load("ld_r3", 3'd3, 8'h00);
        vec("stall1", 0, 1, 3'd3, 1, 3'd0, 0, 3'd1, 0, 0, 1, 0, 8'h08);
        vec("stall2", 0, 1, 3'd3, 1, 3'd0, 0, 3'd1, 0, 0, 1, 0, 8'h08);
        vec("issue",  0, 1, 3'd3, 1, 3'd0, 0, 3'd1, 0, 0, 0, 0, 8'h00);
        idle("idle2", 0, 8'h00);

        // Discard register is never tracked.
        load("ld_r7", 3'd7, 8'h00);
        vec("rd_r7", 0, 1, 3'd7, 1, 3'd7, 1, 3'd1, 0, 0, 0, 0, 8'h00);
        idle("idle3", 0, 8'h00);

        // One independent instruction between: LOAD_LAT-1 = 1 stall.
        load("ld_r4", 3'd4, 8'h00);
        vec("indep",    0, 1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 8'h10);
        vec("rd_r4",    0, 1, 3'd0, 0, 3'd4, 1, 3'd1, 0, 0, 1, 0, 8'h10);
        vec("rd_r4_go", 0, 1, 3'd0, 0, 3'd4, 1, 3'd1, 0, 0, 0, 0, 8'h00);

        // Source fields that are not read never hazard.
        load("ld_r1", 3'd1, 8'h00);
        vec("nouse", 0, 1, 3'd1, 0, 3'd1, 0, 3'd0, 0, 0, 0, 0, 8'h02);
        idle("cnt_r1", 0, 8'h02);
        idle("clr_r1", 0, 8'h00);

        // Reloading a busy register restarts its latency.
        load("ld_r3a", 3'd3, 8'h00);
        load("ld_r3b", 3'd3, 8'h08);
        idle("ovr1", 0, 8'h08);
        idle("ovr2", 0, 8'h08);
        idle("ovr3", 0, 8'h00);

        // Single mispredict: two flush cycles.
        vec("mis1", 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 1, 8'h00);
        idle("fl2", 1, 8'h00);
        idle("fl_end", 0, 8'h00);
        // Second pulse in the second flush cycle: three cycles total.
        vec("misA", 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 1, 8'h00);
        vec("misB", 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 1, 8'h00);
        idle("flC", 1, 8'h00);
        idle("flD", 0, 8'h00);

        // A load sitting in decode during a flush does not issue.
        vec("mis_ld", 0, 1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 1, 8'h00);
        vec("fl_ld",  0, 1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0, 1, 8'h00);
        idle("after_fl", 0, 8'h00);

        // Hazard coincident with mispredict: flush wins, counter keeps running.
        load("ld_r2", 3'd2, 8'h00);
        vec("hz_mis",  0, 1, 3'd2, 1, 3'd0, 0, 3'd1, 0, 1, 0, 1, 8'h04);
        vec("hz_fl",   0, 1, 3'd2, 1, 3'd0, 0, 3'd1, 0, 0, 0, 1, 8'h04);
        vec("hz_done", 0, 1, 3'd2, 1, 3'd0, 0, 3'd1, 0, 0, 0, 0, 8'h00);

        // Reset in the middle of a stall.
        load("ld_r6", 3'd6, 8'h00);
        vec("st_r6",   0, 1, 3'd6, 1, 3'd0, 0, 3'd1, 0, 0, 1, 0, 8'h40);
        vec("rst_mid", 1, 1, 3'd6, 1, 3'd0, 0, 3'd1, 0, 1, 0, 0, 8'h00);
        idle("rel2", 0, 8'h00);

        // Reset in the middle of a flush window.
        vec("mis_r",  0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 1, 8'h00);
        vec("rst_fl", 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
        idle("rel3", 0, 8'h00);

`ifdef PIPE_HAZARD_PERF_CNT_EN
        // Scenario 2 then 4 from a clean reset: 2 stalls, 2 flushes.
        vec("p_rst", 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
        load("p_ld", 3'd3, 8'h00);
        vec("p_st1", 0, 1, 3'd3, 1, 3'd0, 0, 3'd1, 0, 0, 1, 0, 8'h08);
        vec("p_st2", 0, 1, 3'd3, 1, 3'd0, 0, 3'd1, 0, 0, 1, 0, 8'h08);
        vec("p_iss", 0, 1, 3'd3, 1, 3'd0, 0, 3'd1, 0, 0, 0, 0, 8'h00);
        vec("p_mis", 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 1, 8'h00);
        idle("p_fl", 1, 8'h00);
        idle("p_end", 0, 8'h00);
        // Drive the flush counter past saturation.
        for (int i = 0; i < 65540; i++) begin
            vec("p_sat", 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 1, 8'h00);
        end
        idle("p_hold", 1, 8'h00);
`endif

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_miss = n_miss + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
